// File: rtl/approx_prod_accum_if.sv
// Handshake bundle for approx_prod_accum: product stream in, result out.
// slave = accumulator side, master = producer/sink side.
interface approx_prod_accum_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport slave (
    input  in_valid,
    input  in_prod,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_count,
    output out_ovf
  );

  modport master (
    output in_valid,
    output in_prod,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_count,
    input  out_ovf
  );
endinterface

// File: rtl/approx_prod_accum.sv
// Sums a stream of multiplier products into one dot-product result.
// Ports: clk, rst_n (async low), clear (sync abort), bus (slave):
//   in_valid/in_ready/in_prod/in_last, out_valid/out_ready/
//   out_sum/out_count/out_ovf. Macro ACCUM_SAT_EN: saturate on carry.
module approx_prod_accum #(
  parameter int PROD_W    = 16,
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 256,
  localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  approx_prod_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W:0]   sum_w;
  logic [CNT_W-1:0] cnt_inc;
  logic             full_w;

  assign bus.in_ready = (state_q != HOLD);
  assign accept       = bus.in_valid & bus.in_ready;

  // One extra bit keeps the carry-out for overflow detection.
  assign sum_w   = {1'b0, acc_q} + (ACC_W+1)'(bus.in_prod);
  assign cnt_inc = cnt_q + ONE_CNT;
  assign full_w  = (cnt_inc == MAX_CNT);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d = ACC_W'(bus.in_prod);
            cnt_d = ONE_CNT;
            ovf_d = 1'b0;
            if (bus.in_last || (MAX_TERMS == 1))
              state_d = HOLD;
            else
              state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
`ifdef ACCUM_SAT_EN
            // Once saturated, acc stays at max: any add carries again.
            acc_d = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
`else
            acc_d = sum_w[ACC_W-1:0];
`endif
            cnt_d = cnt_inc;
            ovf_d = ovf_q | sum_w[ACC_W];
            if (bus.in_last || full_w)
              state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_approx_prod_accum.sv
// Scoreboard bench for approx_prod_accum (ACC_W=16, MAX_TERMS=4).
// Model keeps accepted products in a queue and sums them on close.
module tb_approx_prod_accum;

  localparam int PROD_W    = 16;
  localparam int ACC_W     = 16;
  localparam int MAX_TERMS = 4;
  localparam int CNT_W     = $clog2(MAX_TERMS + 1);
  localparam longint MAXV  = (longint'(1) << ACC_W) - 1;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } res_t;

  logic clk;
  logic rst_n;
  logic clear;

  approx_prod_accum_if #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) bus ();

  approx_prod_accum #(
    .PROD_W   (PROD_W),
    .ACC_W    (ACC_W),
    .MAX_TERMS(MAX_TERMS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  int   cur[$];
  bit   hold_m = 1'b0;
  bit   took_m = 1'b0;

  task automatic chk(string name, longint act, longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t",
               name, act, req, $time);
    end
  endtask

  function automatic res_t close_result();
    longint total;
    res_t   r;
    total = 0;
    foreach (cur[i]) total += cur[i];
    r.ovf = (total > MAXV);
`ifdef ACCUM_SAT_EN
    r.sum = r.ovf ? ACC_W'(MAXV) : ACC_W'(total);
`else
    r.sum = ACC_W'(total % (MAXV + 1));
`endif
    r.cnt = CNT_W'(cur.size());
    return r;
  endfunction

  // Reference model: tracks products of the open result.
  always @(posedge clk or negedge rst_n) begin
    took_m = 1'b0;
    if (!rst_n) begin
      hold_m = 1'b0;
      cur.delete();
      exp_q.delete();
    end else if (clear) begin
      hold_m = 1'b0;
      cur.delete();
      exp_q.delete();
    end else if (hold_m) begin
      if (bus.out_ready) hold_m = 1'b0;
    end else if (bus.in_valid) begin
      took_m = 1'b1;
      cur.push_back(int'(bus.in_prod));
      if (bus.in_last || cur.size() == MAX_TERMS) begin
        exp_q.push_back(close_result());
        cur.delete();
        hold_m = 1'b1;
      end
    end
  end

  // Monitor: compares outputs against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", longint'(bus.in_ready), longint'(!hold_m));
      chk("out_valid", longint'(bus.out_valid), longint'(hold_m));
      if (hold_m) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          chk("out_sum", longint'(bus.out_sum),
              longint'(exp_q[0].sum));
          chk("out_count", longint'(bus.out_count),
              longint'(exp_q[0].cnt));
          chk("out_ovf", longint'(bus.out_ovf),
              longint'(exp_q[0].ovf));
          if (bus.out_ready && !clear) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int p, bit l);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_prod  = PROD_W'(p);
    bus.in_last  = l;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (took_m) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_accept", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_prod   = 16'd77;
    bus.in_last   = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_sum", longint'(bus.out_sum), 0);
    chk("rst_out_count", longint'(bus.out_count), 0);
    chk("rst_out_ovf", longint'(bus.out_ovf), 0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst_n        = 1'b1;
    cyc();
    chk("post_rst_in_ready", longint'(bus.in_ready), 1);

    send(100, 1'b0);
    send(200, 1'b0);
    send(300, 1'b1);
    chk("t2_sum", longint'(bus.out_sum), 600);
    chk("t2_count", longint'(bus.out_count), 3);
    chk("t2_ovf", longint'(bus.out_ovf), 0);
    cyc();

    bus.out_ready = 1'b0;
    send(5, 1'b0);
    send(6, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'd999;
    repeat (5) cyc();
    chk("t3_held_sum", longint'(bus.out_sum), 11);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc();

    for (int i = 0; i < 6; i++) begin
      send(1, i == 5);
      if (i == 3) begin
        chk("t4_forced_sum", longint'(bus.out_sum), 4);
        chk("t4_forced_count", longint'(bus.out_count), 4);
      end
    end
    chk("t4_last_sum", longint'(bus.out_sum), 2);
    chk("t4_last_count", longint'(bus.out_count), 2);
    cyc();

    send(16'hFFFF, 1'b0);
    send(2, 1'b1);
`ifdef ACCUM_SAT_EN
    chk("t5_sum", longint'(bus.out_sum), 16'hFFFF);
`else
    chk("t5_sum", longint'(bus.out_sum), 1);
`endif
    chk("t5_ovf", longint'(bus.out_ovf), 1);
    cyc();

    send(10, 1'b0);
    send(20, 1'b0);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'd99;
    cyc();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    send(7, 1'b1);
    chk("t6_sum", longint'(bus.out_sum), 7);
    chk("t6_count", longint'(bus.out_count), 1);
    cyc();

    bus.out_ready = 1'b0;
    send(5, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", longint'(bus.out_valid), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_prod   = ($urandom_range(0, 1) != 0) ?
                      PROD_W'($urandom) :
                      PROD_W'($urandom_range(0, 255));
      bus.in_last   = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 1) != 0);
      clear         = ($urandom_range(0, 49) == 0);
      cyc();
    end

    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) cyc();
    chk("drain_scoreboard", longint'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
